mdu_unit: RTL and testbench

//  Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. Takes the

---
 rtl/mdu_unit_pkg.sv | 25 ++
 rtl/mdu_unit.sv | 147 ++++++++++++++
 tb/tb_mdu_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// md_op encodings match the decoder's MD_* codes; unknown codes behave as MD_NONE.
package mdu_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

  // True for the ops that occupy the unit for multiple cycles.
  function automatic logic is_mul_div(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage. Executes mult/multu/div/divu with a fixed
// latency, holds architectural HI/LO and serves mthi/mtlo (mfhi/mflo read HI/LO).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   A, B         forwarded rs / rt operands
//   md_op        operation code (MD_* from mdu_unit_pkg)
//   start        md_op valid this cycle
//   md_is_use    ID holds an md-class instruction
//   busy         operation in flight
//   stall_req    md_is_use & (busy | starting mult/div this cycle)
//   HI, LO       architectural HI / LO
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic        md_is_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // Counter only ever holds N-1.
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     stage_hi_q, stage_hi_d, stage_lo_q, stage_lo_d;
  logic            stage_wr_q, stage_wr_d;

  // Arithmetic. Signed divide is done at 64 bits so 0x80000000 / -1 yields
  // 0x80000000 in the low word instead of overflowing.
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u, quot_s, rem_s;
  logic [31:0] quot_u, rem_u;
  logic        div_zero;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign a_zx   = {32'd0, A};
  assign b_zx   = {32'd0, B};
  assign prod_s = $signed(a_sx) * $signed(b_sx);
  assign prod_u = a_zx * b_zx;
  assign quot_s = $signed(a_sx) / $signed(b_sx);
  assign rem_s  = $signed(a_sx) % $signed(b_sx);
  assign quot_u = A / B;
  assign rem_u  = A % B;
  assign div_zero = (B == 32'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stage_hi_d = stage_hi_q;
    stage_lo_d = stage_lo_q;
    stage_wr_d = stage_wr_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              {stage_hi_d, stage_lo_d} = prod_s;
              stage_wr_d = 1'b1;
              cnt_d      = MultLoad;
              state_d    = StRun;
            end
            MD_MULTU: begin
              {stage_hi_d, stage_lo_d} = prod_u;
              stage_wr_d = 1'b1;
              cnt_d      = MultLoad;
              state_d    = StRun;
            end
            MD_DIV: begin
              stage_hi_d = rem_s[31:0];
              stage_lo_d = quot_s[31:0];
              stage_wr_d = ~div_zero;
              cnt_d      = DivLoad;
              state_d    = StRun;
            end
            MD_DIVU: begin
              stage_hi_d = rem_u;
              stage_lo_d = quot_u;
              stage_wr_d = ~div_zero;
              cnt_d      = DivLoad;
              state_d    = StRun;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (stage_wr_q) begin
            hi_d = stage_hi_q;
            lo_d = stage_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      stage_hi_q <= '0;
      stage_lo_q <= '0;
      stage_wr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      stage_hi_q <= stage_hi_d;
      stage_lo_q <= stage_lo_d;
      stage_wr_q <= stage_wr_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign stall_req = md_is_use & (busy | (start & is_mul_div(md_op) & ~busy));
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: a cycle model compared every cycle plus
// directed vectors with hand-computed HI/LO and busy-length expectations.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  md_op;
  logic        start, md_is_use;
  logic        busy, stall_req;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .md_op    (md_op),
    .start    (start),
    .md_is_use(md_is_use),
    .busy     (busy),
    .stall_req(stall_req),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_wr = 1'b0;
  int          m_left = 0;

  // Sign-magnitude division: quotient truncates toward zero, remainder takes A's sign.
  task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    logic        na, nb;
    logic [31:0] ma, mb, uq, ur;
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    uq = ma / mb;
    ur = ma % mb;
    q  = (na ^ nb) ? (32'd0 - uq) : uq;
    r  = na ? (32'd0 - ur) : ur;
  endtask

  // Advance the model by one rising edge using the inputs present now.
  task automatic model_step();
    longint      ps;
    logic [63:0] pu;
    logic [31:0] q, r;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; p_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT: begin
          ps = longint'($signed(A)) * longint'($signed(B));
          {p_hi, p_lo} = ps; p_wr = 1'b1; m_left = 5;
        end
        MD_MULTU: begin
          pu = {32'd0, A} * {32'd0, B};
          {p_hi, p_lo} = pu; p_wr = 1'b1; m_left = 5;
        end
        MD_DIV, MD_DIVU: begin
          p_wr = (B != 0);
          if (p_wr) begin
            model_div(md_op == MD_DIV, A, B, q, r);
            p_lo = q; p_hi = r;
          end
          m_left = 10;
        end
        MD_MTHI: m_hi = A;
        MD_MTLO: m_lo = A;
        default: ;
      endcase
    end
  endtask

  // Compare every cycle on the falling edge, then step the model.
  initial begin
    logic exp_stall;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_stall = md_is_use & ((m_left > 0) |
                  (start & (md_op >= MD_MULT) & (md_op <= MD_DIVU) & (m_left == 0)));
      chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("cyc_stall", {31'd0, stall_req}, {31'd0, exp_stall});
      chk("cyc_hi", HI, m_hi);
      chk("cyc_lo", LO, m_lo);
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
  endtask

  // Counts busy cycles until busy drops; returns with the commit visible.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[8] = '{
    '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5},
    '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5},
    '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10},
    '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10},
    '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10},
    '{MD_DIVU,  32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h55555555, 10},
    '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5},
    // Divide by zero: HI/LO keep the previous vector's result.
    '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h40000000, 32'h00000000, 10}
  };

  initial begin
    int n;
    reset = 1'b1; A = '0; B = '0; md_op = MD_NONE; start = 1'b0; md_is_use = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    // Arithmetic vectors, including signed overflow and divide by zero.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(n);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      chk($sformatf("v%0d_model_hi", i), m_hi, vecs[i].hi);
      chk($sformatf("v%0d_model_lo", i), m_lo, vecs[i].lo);
    end

    // MTHI then MFHI; MTLO; MTLO attempted while a MULT is in flight.
    issue(MD_MTHI, 32'h12345678, 32'd0);
    @(negedge clk);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MD_MFHI, 32'd0, 32'd0);
    issue(MD_MTLO, 32'h0BADF00D, 32'd0);
    @(negedge clk);
    chk("mtlo_lo", LO, 32'h0BADF00D);
    chk("mfhi_hi", HI, 32'h12345678);
    issue(MD_MULT, 32'd1, 32'd1);
    start = 1'b1; md_op = MD_MTLO; A = 32'hCAFEBABE;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    chk("mtlo_busy_ignored", LO, 32'h0BADF00D);
    wait_done(n);
    chk("mult11_lo", LO, 32'd1);
    chk("mult11_hi", HI, 32'd0);

    // stall_req across a MULT window.
    @(posedge clk); #1;
    md_is_use = 1'b1; start = 1'b1; md_op = MD_MULT; A = 32'd2; B = 32'd3;
    @(negedge clk);
    chk("stall_start", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("stall_busy", {31'd0, stall_req}, 32'd1);
    end
    chk("stall_cycles", n, 5);
    chk("stall_after", {31'd0, stall_req}, 32'd0);
    chk("mult23_lo", LO, 32'd6);
    md_is_use = 1'b0;

    // Reset during busy cycle 3 of a DIV, then a fresh MULT.
    issue(MD_DIV, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    issue(MD_MULT, 32'd3, 32'd4);
    wait_done(n);
    chk("post_rst_cycles", n, 5);
    chk("post_rst_lo", LO, 32'd12);
    chk("post_rst_hi", HI, 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
